// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - RTC bus engine states, shared register addresses and timing defaults
package rtc_pkg;

  // Bus engine states, in the order a cycle walks through them
  typedef enum logic [3:0] {
    S_IDLE,
    S_A_SET,
    S_A_STB,
    S_A_HOLD,
    S_D_SET,
    S_D_STB,
    S_D_HOLD,
    S_DONE,
    S_REC
  } rtc_state_e;

  // RTC register map shared with the control FSM
  localparam logic [7:0] RTC_DIR_SEG    = 8'd33;
  localparam logic [7:0] RTC_DIR_MIN    = 8'd34;
  localparam logic [7:0] RTC_DIR_HORA   = 8'd35;
  localparam logic [7:0] RTC_DIR_DIA    = 8'd36;
  localparam logic [7:0] RTC_DIR_MES    = 8'd37;
  localparam logic [7:0] RTC_DIR_ANIO   = 8'd38;
  localparam logic [7:0] RTC_DIR_T_SEG  = 8'd65;
  localparam logic [7:0] RTC_DIR_T_MIN  = 8'd66;
  localparam logic [7:0] RTC_DIR_T_HORA = 8'd67;
  localparam logic [7:0] RTC_DIR_CTRL   = 8'd10;
  localparam logic [7:0] RTC_DIR_ESTADO = 8'd11;

  // Default timing: clocks per bus phase and idle recovery clocks
  localparam int unsigned T_PH_DEF  = 4;
  localparam int unsigned T_REC_DEF = 4;

endpackage

// File: rtl/rtc_bus_ciclo_temporizador.sv
// rtl/rtc_bus_ciclo_temporizador.sv - loadable 4-bit down-counter with terminal-count flag
module rtc_temporizador (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] carga,
  output logic       tc
);

  logic [3:0] cnt_q;

  // Load on start, otherwise count down and rest at zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= 4'd0;
    end else if (start) begin
      cnt_q <= carga;
    end else if (cnt_q != 4'd0) begin
      cnt_q <= cnt_q - 4'd1;
    end
  end

  assign tc = (cnt_q == 4'd0);

endmodule

// File: rtl/rtc_bus_ciclo.sv
// rtl/rtc_bus_ciclo.sv - multiplexed RTC bus cycle engine; RTC_ESC_VERIFY_EN adds write read-back
module rtc_bus_ciclo
  import rtc_pkg::*;
#(
  parameter int unsigned T_PH  = T_PH_DEF,
  parameter int unsigned T_REC = T_REC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       actesc,
  input  logic       actlec,
  input  logic [7:0] dirreg,
  input  logic [7:0] datoreg,
  output logic       esclisto,
  output logic       memorialisto,
  output logic [7:0] datomem,
  output logic       cs_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic       a_d_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       err_verif
);

  // A phase entered on a load of N-1 leaves on the edge the counter shows zero
  localparam logic [3:0] PH_CARGA  = 4'(T_PH - 1);
  localparam logic [3:0] REC_CARGA = 4'(T_REC - 1);

  rtc_state_e state_q, state_d;
  logic       op_q, op_d;            // 1 = write, 0 = read
  logic       vfy_q, vfy_d;          // current cycle is the write read-back
  logic [7:0] dir_q, dir_d;
  logic [7:0] dato_q, dato_d;
  logic [7:0] datomem_q, datomem_d;
  logic       esc_q, esc_d, mem_q, mem_d;
  logic       cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, a_d_n_q, a_d_n_d;
  logic [7:0] ad_out_q, ad_out_d;
  logic       ad_oe_q, ad_oe_d;
  logic       lectura_d;
  logic       tmr_start, tmr_tc;
  logic [3:0] tmr_carga;
`ifdef RTC_ESC_VERIFY_EN
  logic       err_q, err_d;
`endif

  rtc_temporizador u_tmr (
    .clk   (clk),
    .reset (reset),
    .start (tmr_start),
    .carga (tmr_carga),
    .tc    (tmr_tc)
  );

  // Next state, latches and registered bus outputs decoded from the next state
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    vfy_d     = vfy_q;
    dir_d     = dir_q;
    dato_d    = dato_q;
    datomem_d = datomem_q;
    tmr_start = 1'b0;
    tmr_carga = PH_CARGA;
`ifdef RTC_ESC_VERIFY_EN
    err_d     = err_q;
`endif
    case (state_q)
      S_IDLE: if (actesc || actlec) begin
        op_d      = actesc;
        vfy_d     = 1'b0;
        dir_d     = dirreg;
        dato_d    = datoreg;
        state_d   = S_A_SET;
        tmr_start = 1'b1;
      end
      S_A_SET:  if (tmr_tc) begin state_d = S_A_STB;  tmr_start = 1'b1; end
      S_A_STB:  if (tmr_tc) begin state_d = S_A_HOLD; tmr_start = 1'b1; end
      S_A_HOLD: if (tmr_tc) begin state_d = S_D_SET;  tmr_start = 1'b1; end
      S_D_SET:  if (tmr_tc) begin state_d = S_D_STB;  tmr_start = 1'b1; end
      S_D_STB: if (tmr_tc) begin
        state_d   = S_D_HOLD;
        tmr_start = 1'b1;
        if (!op_q) datomem_d = ad_in;
`ifdef RTC_ESC_VERIFY_EN
        if (vfy_q && (ad_in != dato_q)) err_d = 1'b1;
`endif
      end
      S_D_HOLD: if (tmr_tc) begin
`ifdef RTC_ESC_VERIFY_EN
        if (op_q && !vfy_q) begin
          vfy_d     = 1'b1;
          state_d   = S_A_SET;
          tmr_start = 1'b1;
        end else begin
          state_d = S_DONE;
        end
`else
        state_d = S_DONE;
`endif
      end
      S_DONE: if (!(op_q ? actesc : actlec)) begin
        state_d   = S_REC;
        tmr_start = 1'b1;
        tmr_carga = REC_CARGA;
      end
      S_REC: if (tmr_tc) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Flags follow the originating request only while parked in DONE
    esc_d = (state_d == S_DONE) && op_d && actesc;
    mem_d = (state_d == S_DONE) && !op_d && actlec;

    lectura_d = !op_d || vfy_d;
    cs_n_d    = 1'b1;
    rd_n_d    = 1'b1;
    wr_n_d    = 1'b1;
    a_d_n_d   = 1'b1;
    ad_oe_d   = 1'b0;
    ad_out_d  = 8'h00;
    case (state_d)
      S_A_SET, S_A_STB, S_A_HOLD: begin
        cs_n_d   = 1'b0;
        a_d_n_d  = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = dir_d;
        wr_n_d   = (state_d != S_A_STB);
      end
      S_D_SET, S_D_STB, S_D_HOLD: begin
        cs_n_d = 1'b0;
        if (lectura_d) begin
          rd_n_d = (state_d != S_D_STB);
        end else begin
          wr_n_d   = (state_d != S_D_STB);
          ad_oe_d  = 1'b1;
          ad_out_d = dato_d;
        end
      end
      default: ;
    endcase
  end

  // State, latched request and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      op_q      <= 1'b0;
      vfy_q     <= 1'b0;
      dir_q     <= 8'h00;
      dato_q    <= 8'h00;
      datomem_q <= 8'h00;
      esc_q     <= 1'b0;
      mem_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      a_d_n_q   <= 1'b1;
      ad_out_q  <= 8'h00;
      ad_oe_q   <= 1'b0;
`ifdef RTC_ESC_VERIFY_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      vfy_q     <= vfy_d;
      dir_q     <= dir_d;
      dato_q    <= dato_d;
      datomem_q <= datomem_d;
      esc_q     <= esc_d;
      mem_q     <= mem_d;
      cs_n_q    <= cs_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      a_d_n_q   <= a_d_n_d;
      ad_out_q  <= ad_out_d;
      ad_oe_q   <= ad_oe_d;
`ifdef RTC_ESC_VERIFY_EN
      err_q     <= err_d;
`endif
    end
  end

  assign esclisto     = esc_q;
  assign memorialisto = mem_q;
  assign datomem      = datomem_q;
  assign cs_n         = cs_n_q;
  assign rd_n         = rd_n_q;
  assign wr_n         = wr_n_q;
  assign a_d_n        = a_d_n_q;
  assign ad_out       = ad_out_q;
  assign ad_oe        = ad_oe_q;
`ifdef RTC_ESC_VERIFY_EN
  assign err_verif    = err_q;
`else
  assign err_verif    = 1'b0;
`endif

endmodule

// File: tb/tb_rtc_bus_ciclo.sv
// tb/tb_rtc_bus_ciclo.sv - directed table-driven bench for rtc_bus_ciclo (honours RTC_ESC_VERIFY_EN)
module tb_rtc_bus_ciclo;

`ifdef RTC_ESC_VERIFY_EN
  localparam bit VFY = 1'b1;
`else
  localparam bit VFY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, actesc, actlec;
  logic [7:0] dirreg, datoreg, ad_in, model_rd;
  logic       esclisto, memorialisto, cs_n, rd_n, wr_n, a_d_n, ad_oe, err_verif;
  logic [7:0] datomem, ad_out;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    bit         wr;
    logic [7:0] dir;
    logic [7:0] dato;
    logic [7:0] rdv;
    logic [7:0] exp_dm;
    int         exp_lat;
    int         exp_astb;
    int         exp_dstb;
    int         exp_rd;
    int         exp_err;
  } vec_t;

  vec_t vecs[5];

  rtc_bus_ciclo #(.T_PH(4), .T_REC(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .actesc       (actesc),
    .actlec       (actlec),
    .dirreg       (dirreg),
    .datoreg      (datoreg),
    .esclisto     (esclisto),
    .memorialisto (memorialisto),
    .datomem      (datomem),
    .cs_n         (cs_n),
    .rd_n         (rd_n),
    .wr_n         (wr_n),
    .a_d_n        (a_d_n),
    .ad_out       (ad_out),
    .ad_oe        (ad_oe),
    .ad_in        (ad_in),
    .err_verif    (err_verif)
  );

  always #5 clk = ~clk;

  // RTC model: drives its register value only while the read strobe is low
  assign ad_in = (!rd_n) ? model_rd : 8'h00;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Expected figures for T_PH=4: six phases per bus cycle, doubled when a write is read back
  function automatic vec_t mk(bit wr, logic [7:0] dir, logic [7:0] dato, logic [7:0] rdv,
                              logic [7:0] dm, int err);
    vec_t v;
    v.wr       = wr;
    v.dir      = dir;
    v.dato     = dato;
    v.rdv      = rdv;
    v.exp_dm   = dm;
    v.exp_lat  = (wr && VFY) ? 48 : 24;
    v.exp_astb = (wr && VFY) ? 8 : 4;
    v.exp_dstb = wr ? 4 : 0;
    v.exp_rd   = wr ? (VFY ? 4 : 0) : 4;
    v.exp_err  = err;
    return v;
  endfunction

  task automatic run_txn(input vec_t v, input string tag);
    int lat, astb, dstb, rdc, bad_a, bad_d, oe_viol, other, held;
    lat = -1; astb = 0; dstb = 0; rdc = 0; bad_a = 0; bad_d = 0; oe_viol = 0; other = 0;
    model_rd = v.rdv;
    dirreg   = v.dir;
    datoreg  = v.dato;
    actesc   = v.wr;
    actlec   = !v.wr;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (!cs_n && !a_d_n && !wr_n) begin
        astb++;
        if (ad_out != v.dir || !ad_oe) bad_a++;
      end
      if (!cs_n && a_d_n && !wr_n) begin
        dstb++;
        if (ad_out != v.dato || !ad_oe) bad_d++;
      end
      if (!rd_n) rdc++;
      if (ad_oe && (!rd_n || (!cs_n && a_d_n && !v.wr))) oe_viol++;
      if (v.wr ? memorialisto : esclisto) other++;
      if (v.wr ? esclisto : memorialisto) begin
        lat = n;
        break;
      end
    end
    check({tag, ".latency"}, lat, v.exp_lat);
    check({tag, ".addr_strobes"}, astb, v.exp_astb);
    check({tag, ".data_wr_strobes"}, dstb, v.exp_dstb);
    check({tag, ".rd_strobes"}, rdc, v.exp_rd);
    check({tag, ".addr_bus"}, bad_a, 0);
    check({tag, ".data_bus"}, bad_d, 0);
    check({tag, ".oe_in_read"}, oe_viol, 0);
    check({tag, ".other_flag"}, other, 0);
    check({tag, ".datomem"}, int'(datomem), int'(v.exp_dm));
    check({tag, ".err_verif"}, int'(err_verif), v.exp_err);
    held = 0;
    repeat (3) begin
      @(posedge clk); #1;
      held += int'(v.wr ? esclisto : memorialisto);
    end
    check({tag, ".flag_held"}, held, 3);
    actesc = 1'b0;
    actlec = 1'b0;
    @(posedge clk); #1;
    check({tag, ".flag_drop"}, int'(v.wr ? esclisto : memorialisto), 0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat, rdc, gap, found, seen, saw_stb;
    reset = 1'b0; actesc = 1'b0; actlec = 1'b0;
    dirreg = 8'h00; datoreg = 8'h00; model_rd = 8'h00;

    vecs[0] = mk(1'b1, 8'h21, 8'h59, 8'h59, 8'h00, 0);
    vecs[1] = mk(1'b0, 8'h41, 8'hFF, 8'h12, 8'h12, 0);
    vecs[2] = mk(1'b1, 8'h0A, 8'h33, 8'h33, 8'h12, 0);
    vecs[3] = mk(1'b0, 8'h26, 8'h00, 8'hA5, 8'hA5, 0);
    vecs[4] = mk(1'b1, 8'h43, 8'h00, 8'h00, 8'hA5, 0);

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst.cs_n", int'(cs_n), 1);
    check("rst.rd_n", int'(rd_n), 1);
    check("rst.wr_n", int'(wr_n), 1);
    check("rst.a_d_n", int'(a_d_n), 1);
    check("rst.ad_oe", int'(ad_oe), 0);
    check("rst.ad_out", int'(ad_out), 0);
    check("rst.esclisto", int'(esclisto), 0);
    check("rst.memorialisto", int'(memorialisto), 0);
    check("rst.datomem", int'(datomem), 0);
    check("rst.err_verif", int'(err_verif), 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Both requests together: write first, read after recovery
    model_rd = 8'h3C; dirreg = 8'h22; datoreg = 8'h07;
    actesc = 1'b1; actlec = 1'b1;
    lat = -1; rdc = 0;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (!rd_n) rdc++;
      if (esclisto) begin lat = n; break; end
    end
    check("both.wr_latency", lat, VFY ? 48 : 24);
    check("both.no_read_flag", int'(memorialisto), 0);
    check("both.rd_strobes_in_wr", rdc, VFY ? 4 : 0);
    actesc = 1'b0;
    gap = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (!cs_n) begin gap = n; break; end
    end
    check("both.read_start_gap", gap, 6);
    lat = -1;
    for (int n = 1; n < 200; n++) begin
      @(posedge clk); #1;
      if (memorialisto) begin lat = n; break; end
    end
    check("both.rd_latency", lat, 24);
    check("both.datomem", int'(datomem), 8'h3C);
    actlec = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Reset during write D_STB
    model_rd = 8'h00; dirreg = 8'h23; datoreg = 8'h11; actesc = 1'b1;
    found = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (!wr_n && a_d_n && !cs_n) begin found = 1; break; end
    end
    check("rstmid.reached_dstb", found, 1);
    #2 reset = 1'b0;
    #1;
    check("rstmid.cs_n", int'(cs_n), 1);
    check("rstmid.wr_n", int'(wr_n), 1);
    check("rstmid.rd_n", int'(rd_n), 1);
    check("rstmid.ad_oe", int'(ad_oe), 0);
    actesc = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      seen += int'(esclisto);
    end
    check("rstmid.no_esclisto", seen, 0);
    run_txn(mk(1'b1, 8'h24, 8'h5A, 8'h5A, 8'h00, 0), "rstmid.after");

    // Read dropped during A_HOLD, new request arriving during recovery
    model_rd = 8'h77; dirreg = 8'h41; actlec = 1'b1;
    saw_stb = 0; found = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      if (!cs_n && !a_d_n && !wr_n) saw_stb = 1;
      else if (saw_stb != 0 && !cs_n && !a_d_n && wr_n) begin found = 1; break; end
    end
    check("drop.reached_ahold", found, 1);
    actlec = 1'b0;
    seen = 0; found = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk); #1;
      seen += int'(memorialisto);
      if (cs_n) begin found = 1; break; end
    end
    check("drop.cycle_completed", found, 1);
    repeat (2) begin
      @(posedge clk); #1;
      seen += int'(memorialisto);
    end
    model_rd = 8'h66; actlec = 1'b1;
    gap = -1;
    for (int n = 3; n <= 40; n++) begin
      @(posedge clk); #1;
      seen += int'(memorialisto);
      if (!cs_n) begin gap = n; break; end
    end
    check("drop.no_memorialisto", seen, 0);
    check("drop.restart_gap", gap, 6);
    lat = -1;
    for (int n = 1; n < 200; n++) begin
      @(posedge clk); #1;
      if (memorialisto) begin lat = n; break; end
    end
    check("drop.next_rd_latency", lat, 24);
    check("drop.next_datomem", int'(datomem), 8'h66);
    actlec = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // Write whose read-back differs
    run_txn(mk(1'b1, 8'h21, 8'h59, 8'h58, 8'h66, VFY ? 1 : 0), "verify");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rtc_bus_ciclo.md
Name: rtc_bus_ciclo

Overview:
Downstream bus engine for the RTC control FSM. Converts the level requests actesc/actlec, with latched address dirreg and data datoreg, into timed multiplexed address/data bus cycles on the external RTC (cs_n, rd_n, wr_n, a_d_n, shared AD bus). Returns level completion flags esclisto/memorialisto and read data datomem to the control FSM. Sits between the control FSM and the top-level tristate pad for AD.

Parameters:
T_PH, 4, clock cycles per bus phase (1..15); 4-bit phase timer.
T_REC, 4, minimum IDLE cycles between consecutive bus cycles (1..15).

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
actesc  in  1  write request, level; held until esclisto seen
actlec  in  1  read request, level; held until memorialisto seen
dirreg  in  8  RTC register address
datoreg  in  8  write data
esclisto  out  1  write complete, level
memorialisto  out  1  read complete, level
datomem  out  8  last read data, registered
cs_n  out  1  RTC chip select
rd_n  out  1  RTC read strobe
wr_n  out  1  RTC write strobe
a_d_n  out  1  0 = address phase, 1 = data phase
ad_out  out  8  AD bus drive value
ad_oe  out  1  AD pad output enable
ad_in  in  8  AD bus sampled value
err_verif  out  1  write-verify mismatch (sticky; see Optional Feature)

Behaviour:
- Async reset (reset=0): state IDLE, timers 0; cs_n=rd_n=wr_n=a_d_n=1, ad_oe=0, ad_out=0, esclisto=memorialisto=0, datomem=0, err_verif=0. Applies immediately, including mid-cycle; an aborted cycle never reports done.
- All outputs are registered.
- States: IDLE, A_SET, A_STB, A_HOLD, D_SET, D_STB, D_HOLD, DONE, REC.
- Each of A_SET through D_HOLD lasts exactly T_PH cycles, counted by the phase timer.
- IDLE: cs_n=1. On an edge with actesc=1 or actlec=1: latch op (write if actesc, else read), dirreg and datoreg; go to A_SET.
  - Both requests high: write wins; read is served on a later cycle.
- A_SET: cs_n=0, a_d_n=0, ad_oe=1, ad_out=address, wr_n=1.
- A_STB: as A_SET, wr_n=0 (address latch).
- A_HOLD: wr_n=1, address still driven.
- D_SET: a_d_n=1.
  - Write: ad_oe=1, ad_out=data.
  - Read: ad_oe=0.
- D_STB: write drives wr_n=0; read drives rd_n=0. Read captures ad_in into datomem on the last D_STB cycle.
- D_HOLD: strobes high; write data still driven; cs_n=0.
- DONE: cs_n=1, ad_oe=0. Assert esclisto (write) or memorialisto (read) and hold it while the originating request stays high. When that request drops: clear the flag, go to REC.
- REC: idle bus for T_REC cycles, then IDLE. Requests are ignored in REC.
- Latency: done flag is visible after edge 6*T_PH counted from the sampling edge; 24 cycles at defaults.
- Request dropped mid-cycle: cycle completes. DONE sees the request low, asserts no flag, and goes to REC next cycle.
- datomem holds its value until the next read completes; writes never alter it.
- ad_oe is never 1 while rd_n=0.

Optional Feature:
RTC_ESC_VERIFY_EN:
- Defined: after a write's D_HOLD, run a full read cycle (A_SET..D_HOLD) to the same address, then enter DONE.
  - Readback != written data: set err_verif, sticky until reset.
  - Write latency becomes 12*T_PH.
  - datomem is not updated by the verify read.
- Undefined: no verify cycle; err_verif tied 0.

Decomposition:
- Package rtc_pkg holds:
  - the state enum encodings;
  - RTC register address constants shared with the control FSM (33..38, 65..67, 10, 11);
  - default T_PH and T_REC.
- Natural sub-module: rtc_temporizador, a loadable 4-bit down-counter. It has inputs for load value and start, and raises a terminal-count flag. It is used for both phase timing and recovery timing.

Test Plan:
- Write dirreg=8'h21, datoreg=8'h59, T_PH=4:
  - A_STB has wr_n=0 for 4 cycles with ad_out=8'h21, a_d_n=0.
  - D_STB has wr_n=0 with ad_out=8'h59, a_d_n=1.
  - esclisto rises 24 cycles after the request; it falls the cycle after actesc drops.
- Read dirreg=8'h41, model drives ad_in=8'h12 during D_STB: datomem=8'h12, memorialisto high at cycle 24, rd_n low 4 cycles, ad_oe=0 throughout the data phase.
- actesc and actlec raised together: write cycle first; after actesc drops and T_REC elapses, the read cycle runs.
- reset pulled low during D_STB of a write: all strobes high and cs_n=1 immediately; esclisto never asserts; new request after release completes normally.
- actlec dropped during A_HOLD: cycle completes, memorialisto stays 0, REC lasts 4 cycles; a request arriving during REC starts only after REC ends.
- With RTC_ESC_VERIFY_EN, model returns 8'h58 for written 8'h59: err_verif=1, esclisto at cycle 48; without the macro err_verif stays 0.
